// File: rtl/cpu_control_fsm.sv
// Multi-cycle main control unit for the 16-bit RISC CPU.
// Sequences fetch/decode/execute/memory/writeback; outputs decode from the state register.
module cpu_control_fsm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       wb_sel,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_EXEC     = 4'd7;
    localparam logic [3:0] S_ALU_WB   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;

    localparam logic [3:0] OP_LW  = 4'b0000;
    localparam logic [3:0] OP_SW  = 4'b0001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNQ = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // NOTE: async reset plus non-blocking assignment keeps the state register race-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:           state_d = S_MEM_ADDR;
                    4'b0010, 4'b0011, 4'b0100, 4'b0101,
                    4'b0110, 4'b0111, 4'b1000, 4'b1001:
                                            state_d = S_EXEC;
                    OP_BEQ, OP_BNQ:         state_d = S_BRANCH;
                    OP_JMP:                 state_d = S_JUMP;
                    default:                state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC:     state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        reg_we    = 1'b0;
        reg_dst   = 1'b0;
        wb_sel    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 2'b10;
                illegal   = (opcode == 4'b1010) || (opcode == 4'b1110) || (opcode == 4'b1111);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WB: begin
                reg_we = 1'b1;
                wb_sel = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
            end
            S_ALU_WB: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_we     = (opcode == OP_BEQ) ? zero : !zero;
            end
            S_JUMP: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: per-instruction expected output traces
// are built from the instruction class and wait counts, then compared every cycle.
module tb_cpu_control_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_we, reg_dst, wb_sel, illegal;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_control_fsm dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel), .illegal(illegal), .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_we, iord, ir_we, pc_we;
        logic [1:0] pc_src;
        logic       a;
        logic [1:0] b;
        logic [1:0] op;
        logic       reg_we, reg_dst, wb_sel, illegal;
    } obs_t;

    typedef struct packed {
        logic rdy;
        obs_t o;
    } exp_t;

    exp_t exp_q[$];
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Expected observation for one cycle, from the per-state output table.
    function automatic exp_t cyc(input int st, input logic rdy, input logic brw, input logic ill);
        exp_t e;
        e = '0;
        e.rdy  = rdy;
        e.o.st = 4'(st);
        case (st)
            1: begin e.o.mem_req = 1; e.o.b = 2'b01; e.o.op = 2'b10; e.o.ir_we = rdy; e.o.pc_we = rdy; end
            2: begin e.o.b = 2'b11; e.o.op = 2'b10; e.o.illegal = ill; end
            3: begin e.o.a = 1; e.o.b = 2'b10; e.o.op = 2'b10; end
            4: begin e.o.mem_req = 1; e.o.iord = 1; end
            5: begin e.o.reg_we = 1; e.o.wb_sel = 1; end
            6: begin e.o.mem_req = 1; e.o.iord = 1; e.o.mem_we = 1; end
            7: begin e.o.a = 1; end
            8: begin e.o.reg_we = 1; e.o.reg_dst = 1; end
            9: begin e.o.a = 1; e.o.op = 2'b01; e.o.pc_src = 2'b01; e.o.pc_we = brw; end
            10: begin e.o.pc_src = 2'b10; e.o.pc_we = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic push_mem(input int st, input int waits);
        for (int i = 0; i < waits; i++) exp_q.push_back(cyc(st, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(cyc(st, 1'b1, 1'b0, 1'b0));
    endtask

    // mem_ready is driven high in non-memory cycles to show it is ignored there.
    task automatic build(input logic [3:0] op, input int fw, input int mw, input logic z);
        int o;
        o = int'(op);
        push_mem(1, fw);
        if (o == 10 || o >= 14) begin
            exp_q.push_back(cyc(2, 1'b1, 1'b0, 1'b1));
        end else begin
            exp_q.push_back(cyc(2, 1'b1, 1'b0, 1'b0));
            if (o <= 1) begin
                exp_q.push_back(cyc(3, 1'b1, 1'b0, 1'b0));
                if (o == 0) begin
                    push_mem(4, mw);
                    exp_q.push_back(cyc(5, 1'b1, 1'b0, 1'b0));
                end else begin
                    push_mem(6, mw);
                end
            end else if (o <= 9) begin
                exp_q.push_back(cyc(7, 1'b1, 1'b0, 1'b0));
                exp_q.push_back(cyc(8, 1'b1, 1'b0, 1'b0));
            end else if (o == 11) begin
                exp_q.push_back(cyc(9, 1'b1, z, 1'b0));
            end else if (o == 12) begin
                exp_q.push_back(cyc(9, 1'b1, !z, 1'b0));
            end else begin
                exp_q.push_back(cyc(10, 1'b1, 1'b0, 1'b0));
            end
        end
    endtask

    obs_t got;
    always_comb begin
        got = '0;
        got.st = state; got.mem_req = mem_req; got.mem_we = mem_we; got.iord = iord;
        got.ir_we = ir_we; got.pc_we = pc_we; got.pc_src = pc_src; got.a = alu_src_a;
        got.b = alu_src_b; got.op = alu_op; got.reg_we = reg_we; got.reg_dst = reg_dst;
        got.wb_sel = wb_sel; got.illegal = illegal;
    end

    always @(negedge clk) begin
        if (chk_en && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("trace op=%0h st=%0d", opcode, e.o.st), 32'(got), 32'(e.o));
        end
    end

    // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 of the next FETCH.
    task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z,
                             input int exp_len);
        opcode = op;
        zero   = z;
        build(op, fw, mw, z);
        check($sformatf("cycles op=%0h", op), 32'(exp_q.size()), 32'(exp_len));
        chk_en = 1'b1;
        while (exp_q.size() > 0) begin
            mem_ready = exp_q[0].rdy;
            @(negedge clk);
            @(posedge clk); #1;
        end
        chk_en = 1'b0;
        check($sformatf("back_to_fetch op=%0h", op), 32'(state), 32'd1);
    endtask

    task automatic release_reset(input string tag);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check({tag, "_idle_after_release"}, 32'(state), 32'd0);
        @(posedge clk); #1;
        check({tag, "_fetch_2nd_edge"}, 32'(state), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        opcode    = 4'b0010;
        zero      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_state", 32'(state), 32'd0);
            check("reset_outputs", 32'(got), 32'd0);
        end
        release_reset("por");

        run_instr(4'b0010, 0, 0, 1'b0, 4);   // ADD
        run_instr(4'b0000, 2, 2, 1'b0, 9);   // LW with waits
        run_instr(4'b0000, 0, 0, 1'b0, 5);   // LW no waits
        run_instr(4'b0001, 0, 0, 1'b0, 4);   // SW
        run_instr(4'b0001, 1, 3, 1'b1, 8);   // SW with waits
        run_instr(4'b1011, 0, 0, 1'b1, 3);   // BEQ taken
        run_instr(4'b1011, 0, 0, 1'b0, 3);   // BEQ not taken
        run_instr(4'b1100, 0, 0, 1'b0, 3);   // BNQ taken
        run_instr(4'b1100, 0, 0, 1'b1, 3);   // BNQ not taken
        run_instr(4'b1101, 0, 0, 1'b0, 3);   // JMP
        run_instr(4'b1110, 0, 0, 1'b0, 2);   // illegal
        run_instr(4'b1010, 1, 0, 1'b0, 3);   // illegal, fetch wait
        run_instr(4'b1111, 0, 0, 1'b0, 2);   // illegal
        run_instr(4'b1001, 0, 0, 1'b1, 4);   // SLT

        // Reset while MEM_RD is waiting on memory.
        opcode    = 4'b0000;
        mem_ready = 1'b1;
        for (int i = 0; i < 10 && state != 4'd4; i++) begin
            if (state == 4'd3) mem_ready = 1'b0;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        check("midrst_in_mem_rd", 32'(state), 32'd4);
        check("midrst_req_high", 32'(mem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_req_dropped", 32'(mem_req), 32'd0);
        check("midrst_state_idle", 32'(state), 32'd0);
        check("midrst_iord_dropped", 32'(iord), 32'd0);
        mem_ready = 1'b1;
        release_reset("mid");
        run_instr(4'b0011, 0, 0, 1'b0, 4);   // SUB after recovery

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
# cpu_control_fsm

Multi-cycle main control unit for the 16-bit RISC CPU. It sequences each instruction through fetch, decode, execute, memory and writeback states, driving the datapath select/enable lines and the 2-bit `alu_op` consumed by `alu_control`. Memory accesses use a req/ready handshake with unbounded wait states. All outputs are Moore, decoded from the state register only.

## Interface
Parameters:
- none (ISA fixed: 4-bit opcode, word-addressed PC).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  4  IR[15:12]; stable from DECODE until the next FETCH.
- `zero`  in  1  ALU zero flag, combinational from the current ALU result.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request; held high until `mem_ready`.
- `mem_we`  out  1  1 = write, 0 = read; valid only while `mem_req` is high.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_we`  out  1  IR load enable.
- `pc_we`  out  1  PC load enable.
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = rs.
- `alu_src_b`  out  2  ALU B input: 00 = rt, 01 = constant 1, 10 = sign-extended immediate, 11 = sign-extended branch offset.
- `alu_op`  out  2  ALU op class: 10 = add, 01 = subtract/compare, 00 = function from opcode.
- `reg_we`  out  1  register file write enable.
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd.
- `wb_sel`  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- `illegal`  out  1  one-cycle pulse in DECODE when the opcode is undefined.
- `state`  out  4  current state encoding (debug/verification).

## Operation
Opcode map:
- 0000 = LW; 0001 = SW.
- 0010–1001 = data processing (ADD, SUB, NOT, LSL, LSR, AND, OR, SLT).
- 1011 = BEQ; 1100 = BNQ; 1101 = JMP.
- 1010, 1110, 1111 = illegal, executed as a NOP.

States (encoding in brackets). Any output not listed is 0.
- IDLE [0]: entered only by reset; all outputs 0. Next state: FETCH.
- FETCH [1]: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=10, `pc_src`=00.
  - `ir_we` = `pc_we` = `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE [2]: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=10; this precomputes the branch target into ALUOut. Next state by opcode:
  - LW/SW → MEM_ADDR.
  - data processing → EXEC.
  - BEQ/BNQ → BRANCH.
  - JMP → JUMP.
  - illegal → FETCH, with `illegal`=1.
- MEM_ADDR [3]: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=10. Next state: MEM_RD for LW, MEM_WR for SW.
- MEM_RD [4]: `mem_req`=1, `iord`=1, `mem_we`=0. Waits for `mem_ready`, then goes to MEM_WB.
- MEM_WB [5]: `reg_we`=1, `wb_sel`=1, `reg_dst`=0. Next state: FETCH.
- MEM_WR [6]: `mem_req`=1, `iord`=1, `mem_we`=1. Waits for `mem_ready`, then goes to FETCH.
- EXEC [7]: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=00. Next state: ALU_WB.
- ALU_WB [8]: `reg_we`=1, `wb_sel`=0, `reg_dst`=1. Next state: FETCH.
- BRANCH [9]: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01.
  - `pc_we` = `zero` for BEQ, `!zero` for BNQ.
  - Next state: FETCH.
- JUMP [10]: `pc_src`=10, `pc_we`=1. Next state: FETCH.
- Encodings 11–15 are unreachable; if entered, the next state is IDLE.

## Timing
- Reset: on `reset_n`=0 the state is forced to IDLE immediately (asynchronously), so every output goes to 0 within the same cycle, including a `mem_req` that was mid-handshake. The first FETCH occurs in the second rising edge after `reset_n` deasserts.
- Cycle counts with zero wait states (`mem_ready` high in the first request cycle), FETCH through the last state:
  - ALU instruction: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/BNQ, JMP: 3 cycles.
  - Illegal: 2 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- Handshake:
  - `mem_req` asserts on entry to a memory state and holds, with `iord`/`mem_we` stable, until the cycle in which `mem_ready`=1.
  - That cycle completes the transfer; the FSM leaves the state on the following edge.
  - `mem_ready` is ignored outside the memory states (FETCH, MEM_RD, MEM_WR).
- `ir_we` and `pc_we` in FETCH assert only in the `mem_ready` cycle, so the PC increments exactly once per fetch regardless of wait states.
- `zero` is sampled combinationally in BRANCH only.

## Test plan
- Reset and ADD: hold `reset_n`=0 for 3 cycles with `mem_ready`=1, then release and drive opcode=0010.
  - Required: `state` sequence 0,1,2,7,8,1.
  - `alu_op`=00 in EXEC; `reg_we`=1 and `reg_dst`=1 in ALU_WB only.
- LW with wait states: opcode=0000, `mem_ready` low for 2 cycles in both FETCH and MEM_RD.
  - Required: `mem_req` high for 3 cycles in each of those states.
  - `ir_we` and `pc_we` pulse once; `wb_sel`=1 in MEM_WB; 9 cycles in total.
- SW: opcode=0001.
  - Required: `mem_we`=1 and `iord`=1 in MEM_WR; `reg_we` never asserts; return to FETCH after 4 cycles.
- Branches: run the four combinations BEQ/`zero`=1, BEQ/`zero`=0, BNQ/`zero`=0, BNQ/`zero`=1.
  - Required: `pc_we` in BRANCH = 1, 0, 1, 0 respectively, with `pc_src`=01 and `alu_op`=01 in all four.
- JMP and illegal: drive opcode=1101, then opcode=1110.
  - JMP required: `pc_src`=10 with `pc_we`=1.
  - Illegal required: `illegal` pulses for 1 cycle in DECODE, then FETCH follows; `reg_we` and `mem_req` stay low outside FETCH.
- Reset mid-access: assert `reset_n`=0 in MEM_RD with `mem_req`=1.
  - Required: `mem_req`=0 and `state`=0 before the next clock edge; FETCH follows 2 edges after release.
